// File: rtl/rf_write_arbiter_if.sv
// Writeback bundle between the ALU/load units, scoreboard and register file.
// Groups request handshakes, reservation, hazard check and write port.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    localparam int NREG = 2 ** ADDR_W;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] chk_a;
    logic [ADDR_W-1:0] chk_b;
    logic              hazard;
    logic [NREG-1:0]   busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              sb_err;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output rsv_valid, rsv_addr, chk_a, chk_b,
        input  alu_ready, ld_ready, hazard, busy,
        input  rf_we, rf_waddr, rf_wdata, sb_err
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  rsv_valid, rsv_addr, chk_a, chk_b,
        output alu_ready, ld_ready, hazard, busy,
        output rf_we, rf_waddr, rf_wdata, sb_err
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter with load scoreboard and WAW blocking.
// Define RF_ARB_ROUND_ROBIN_EN to alternate contested grants; default favours loads.
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_nxt;
    logic              err_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic alu_elig;
    logic contest;
    logic ld_pref;
    logic ld_fire;
    logic alu_fire;

    assign alu_elig = ~busy_q[bus.alu_addr];
    assign contest  = bus.ld_valid & bus.alu_valid & alu_elig;

`ifdef RF_ARB_ROUND_ROBIN_EN
    typedef enum logic {LG_ALU, LG_LD} lg_e;

    lg_e lg_q;
    lg_e lg_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) lg_q <= LG_ALU;
        else        lg_q <= lg_nxt;
    end

    // Only contests move the pointer; uncontested grants leave it alone.
    always_comb begin
        lg_nxt = lg_q;
        if (rst_n && contest)
            lg_nxt = ld_fire ? LG_LD : LG_ALU;
    end

    assign ld_pref = (lg_q == LG_ALU);
`else
    assign ld_pref = 1'b1;
`endif

    assign ld_fire  = rst_n & bus.ld_valid & ~(contest & ~ld_pref);
    assign alu_fire = rst_n & bus.alu_valid & alu_elig & ~ld_fire;

    // Reservation is applied after the clear so a same-edge set wins.
    always_comb begin
        busy_nxt = busy_q;
        if (ld_fire)
            busy_nxt[bus.ld_addr] = 1'b0;
        if (bus.rsv_valid)
            busy_nxt[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (ld_fire && !busy_q[bus.ld_addr])
                err_q <= 1'b1;
            we_q <= ld_fire | alu_fire;
            if (ld_fire) begin
                waddr_q <= bus.ld_addr;
                wdata_q <= bus.ld_data;
            end else if (alu_fire) begin
                waddr_q <= bus.alu_addr;
                wdata_q <= bus.alu_data;
            end
        end
    end

    assign bus.ld_ready  = ld_fire;
    assign bus.alu_ready = alu_fire;
    assign bus.hazard    = busy_q[bus.chk_a] | busy_q[bus.chk_b];
    assign bus.busy      = busy_q;
    assign bus.sb_err    = err_q;
    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios then random traffic.
// Expected writes are queued by the stimulus side and checked by a monitor.
module tb_rf_write_arbiter;
    localparam int DW = 8;
    localparam int AW = 2;

    typedef struct {
        bit       we;
        bit [1:0] addr;
        bit [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    wr_t exp_q[$];

    bit       m_busy[4];
    bit       m_err;
    bit       m_turn_ld;
    bit       m_known = 0;
    bit [1:0] m_waddr;
    bit [7:0] m_wdata;
    int       grants_ld;
    int       grants_alu;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each cycle after a stimulus step, the write port must match.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
            chk("rf_waddr", {30'd0, bus.rf_waddr}, {30'd0, e.addr});
            chk("rf_wdata", {24'd0, bus.rf_wdata}, {24'd0, e.data});
        end
    end

    function automatic bit [3:0] busy_vec();
        bit [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic cyc(input bit rst, input bit av, input bit [1:0] aa,
                       input bit [7:0] ad, input bit lv, input bit [1:0] la,
                       input bit [7:0] ld, input bit rv, input bit [1:0] ra,
                       input bit [1:0] ca, input bit [1:0] cb);
        bit alu_ok, exp_ar, exp_lr, cont;
        wr_t w;
        @(negedge clk);
        rst_n = rst;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ld;
        bus.rsv_valid = rv; bus.rsv_addr = ra;
        bus.chk_a = ca; bus.chk_b = cb;
        #1;
        exp_ar = 0; exp_lr = 0; cont = 0;
        if (rst) begin
            alu_ok = av && !m_busy[aa];
            cont = lv && alu_ok;
            if (cont) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
                exp_lr = m_turn_ld;
`else
                exp_lr = 1;
`endif
                exp_ar = !exp_lr;
            end else begin
                exp_lr = lv;
                exp_ar = alu_ok;
            end
        end
        chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, exp_lr});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, exp_ar});
        if (m_known) begin
            chk("hazard", {31'd0, bus.hazard}, {31'd0, m_busy[ca] | m_busy[cb]});
            chk("busy", {28'd0, bus.busy}, {28'd0, busy_vec()});
            chk("sb_err", {31'd0, bus.sb_err}, {31'd0, m_err});
        end
        if (!rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_err = 0; m_turn_ld = 1;
            m_waddr = 0; m_wdata = 0;
            m_known = 1;
            w.we = 0;
        end else begin
            w.we = exp_lr | exp_ar;
            if (exp_lr) begin
                m_waddr = la; m_wdata = ld; grants_ld++;
                if (!m_busy[la]) m_err = 1;
                m_busy[la] = 0;
            end else if (exp_ar) begin
                m_waddr = aa; m_wdata = ad; grants_alu++;
            end
            if (rv) m_busy[ra] = 1;
            if (cont) m_turn_ld = !exp_lr;
        end
        w.addr = m_waddr; w.data = m_wdata;
        exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int gl, ga;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.rsv_valid = 0; bus.rsv_addr = 0; bus.chk_a = 0; bus.chk_b = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Plain ALU write.
        cyc(1, 1, 2, 8'h5A, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Reserve r1, ALU blocked, load returns, ALU retries.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 1, 8'hC4, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 8'hC4, 1, 1, 8'h33, 0, 0, 1, 2);
        cyc(1, 1, 1, 8'hC4, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Four-cycle contest, addrs 0 and 3, after a fresh reset.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        gl = grants_ld; ga = grants_alu;
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 0, 8'(8'h10 + i), 1, 3, 8'(8'h20 + i), 0, 0, 0, 3);
`ifdef RF_ARB_ROUND_ROBIN_EN
        chk("rr_ld_grants", grants_ld - gl, 2);
        chk("rr_alu_grants", grants_alu - ga, 2);
`else
        chk("fixed_ld_grants", grants_ld - gl, 4);
        chk("fixed_alu_grants", grants_alu - ga, 0);
`endif
        idle(1);

        // Same-edge reserve and clear on r3.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
        cyc(1, 0, 0, 0, 1, 3, 8'h77, 1, 3, 3, 0);
        idle(1);

        // Unreserved load sets the sticky error; only reset clears it.
        cyc(1, 0, 0, 0, 1, 0, 8'h99, 0, 0, 0, 0);
        idle(10);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Reset lands on a cycle with an ALU request pending.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
        cyc(0, 1, 1, 8'hEE, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            bit r, av, lv, rv;
            bit [1:0] la;
            r  = ($urandom_range(0, 199) != 0);
            av = $urandom_range(0, 1);
            rv = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 2) == 0);
            la = 2'($urandom);
            if ($urandom_range(0, 7) != 0)
                for (int k = 0; k < 4; k++)
                    if (m_busy[2'(la + k)]) begin
                        la = 2'(la + k);
                        break;
                    end
            cyc(r, av, 2'($urandom), 8'($urandom), lv, la, 8'($urandom),
                rv, 2'($urandom), 2'($urandom), 2'($urandom));
        end

        idle(1);
        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, register data width.
REQ-002 Parameter: ADDR_W, default 2, register address width; NREG = 2**ADDR_W = 4.
REQ-003 Clock and reset: one clock and one reset, reset synchronous and active-low; ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 alu_valid / alu_addr / alu_data  input  1 / ADDR_W / DATA_W  ALU writeback request.
REQ-007 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-008 ld_valid / ld_addr / ld_data  input  1 / ADDR_W / DATA_W  load-return writeback request.
REQ-009 ld_ready  output  1  load request accepted this cycle (combinational).
REQ-010 rsv_valid / rsv_addr  input  1 / ADDR_W  reserve destination of an issued load.
REQ-011 chk_a / chk_b  input  ADDR_W each  source registers of the instruction in decode.
REQ-012 hazard  output  1  chk_a or chk_b busy (combinational).
REQ-013 busy  output  NREG  scoreboard, bit i = register i has a pending load.
REQ-014 rf_we / rf_waddr / rf_wdata  output  1 / ADDR_W / DATA_W  registered drive to the register-file write port.
REQ-015 sb_err  output  1  sticky scoreboard error.

Function
REQ-016 Transfer occurs on valid&&ready; at most one transfer per cycle.
REQ-017 Winner's addr/data appear on rf_waddr/rf_wdata with rf_we=1 in the following cycle; otherwise rf_we=0 and rf_waddr/rf_wdata hold.
REQ-018 ld is always eligible; alu is eligible only when busy[alu_addr]=0 (WAW block).
REQ-019 Exactly one eligible requester valid: that requester gets ready=1.
REQ-020 Both eligible and valid (contest): resolved per REQ-030/031; loser ready=0 and it retries.
REQ-021 ready=0 whenever the corresponding valid=0.
REQ-022 rsv_valid sets busy[rsv_addr] at the clock edge.
REQ-023 Accepted ld clears busy[ld_addr] at the clock edge.
REQ-024 Same edge, rsv_addr==ld_addr, both events: busy stays 1 (set wins).
REQ-025 rsv to an already-busy register: busy stays 1, sb_err unaffected.
REQ-026 Accepted ld with busy[ld_addr]=0: sb_err set to 1, holds until reset; write still performed.
REQ-027 hazard = busy[chk_a] | busy[chk_b], same-cycle, reflects registered busy only.
REQ-028 last_grant register records the winner of each contest only; it does not change on uncontested grants.

Reset
REQ-029 rst_n=0 at an edge: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, sb_err=0, last_grant=ALU; transfers in that cycle are discarded and ready outputs are 0 while rst_n=0.

Configuration
REQ-030 Macro RF_ARB_ROUND_ROBIN_EN defined: contest granted to the requester not recorded in last_grant (first contest after reset goes to ld, next to alu, alternating).
REQ-031 RF_ARB_ROUND_ROBIN_EN undefined: contest always granted to ld; last_grant not implemented.

Verification
REQ-032 alu_valid=1, addr=2, data=0x5A, busy=0 -> alu_ready=1; next cycle rf_we=1, rf_waddr=2, rf_wdata=0x5A.
REQ-033 rsv_valid addr=1, then alu_valid addr=1 -> alu_ready=0, hazard=1 with chk_a=1; ld addr=1 data=0x33 accepted -> busy[1]=0 next cycle, alu then accepted, rf writes 0x33 then alu data.
REQ-034 Both valid for 4 cycles (addrs 0/3, no busy), RR enabled -> grant order ld, alu, ld, alu; RR disabled -> ld every cycle.
REQ-035 rsv addr=3 and accepted ld addr=3 same cycle, busy[3]=1 beforehand -> busy[3]=1 after, sb_err=0.
REQ-036 ld accepted to addr=0 with busy=0 -> sb_err=1, stays 1 for 10 cycles, cleared only by rst_n=0.
REQ-037 rst_n=0 asserted while alu transfer pending -> next cycle rf_we=0, busy=0, no write issued.
